// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
package alu_seq_pkg;

    localparam int N_DEF  = 4;
    localparam int FW_DEF = 4;

    localparam logic [2:0] PH_A    = 3'd0;
    localparam logic [2:0] PH_B    = 3'd1;
    localparam logic [2:0] PH_F    = 3'd2;
    localparam logic [2:0] PH_EXEC = 3'd3;
    localparam logic [2:0] PH_SHOW = 3'd4;

    typedef enum logic [2:0] {
        S_A    = PH_A,
        S_B    = PH_B,
        S_F    = PH_F,
        S_EXEC = PH_EXEC,
        S_SHOW = PH_SHOW
    } state_t;

    function automatic int wmax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alu_operand_sequencer_button_conditioner.sv
// Button synchroniser, optional debouncer and rising-edge detector.
// ALU_SEQ_DEBOUNCE_EN compiles in the debounce counter.
module button_conditioner #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic step
);

    logic       s0;
    logic       s1;
    logic       level;
    logic       prev;
    logic       armed;
    logic [1:0] fill;

    // Steps are only armed once a genuine released level has been seen,
    // so a press held across reset cannot fire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0    <= 1'b0;
            s1    <= 1'b0;
            prev  <= 1'b0;
            armed <= 1'b0;
            fill  <= 2'd0;
        end else begin
            s0   <= btn;
            s1   <= s0;
            prev <= level;
            if (fill != 2'd2)
                fill <= fill + 2'd1;
            if (fill == 2'd2 && !s1 && !level)
                armed <= 1'b1;
        end
    end

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            acc <= 1'b0;
        end else if (s1 == acc) begin
            cnt <= '0;
        end else if (cnt == CW'(DB_CYCLES - 1)) begin
            acc <= s1;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign level = acc;
`else
    logic db_unused;
    assign db_unused = (DB_CYCLES > 0);
    assign level     = s1;
`endif

    assign step = level & ~prev & armed;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Stepped A/B/F entry and ALU result capture for the board ALU.
// Build with ALU_SEQ_DEBOUNCE_EN to debounce the step button.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int FW        = FW_DEF,
    parameter int DB_CYCLES = 500000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [wmax(N,FW)-1:0]   sw,
    input  logic                    btn,
    output logic [N-1:0]            A,
    output logic [N-1:0]            B,
    output logic [FW-1:0]           F,
    output logic                    alu_go,
    input  logic [N-1:0]            Y_in,
    input  logic                    Cout_in,
    input  logic                    OV_in,
    output logic [N-1:0]            Y_q,
    output logic                    Cout_q,
    output logic                    OV_q,
    output logic                    valid,
    output logic [2:0]              phase
);

    logic   step;
    state_t state;
    state_t nxt;

    button_conditioner #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .step  (step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_A;
        else
            state <= nxt;
    end

    always_comb begin
        nxt    = state;
        alu_go = 1'b0;
        valid  = 1'b0;
        unique case (state)
            S_A:    if (step) nxt = S_B;
            S_B:    if (step) nxt = S_F;
            S_F:    if (step) nxt = S_EXEC;
            S_EXEC: begin
                alu_go = 1'b1;
                nxt    = S_SHOW;
            end
            S_SHOW: begin
                valid = 1'b1;
                if (step) nxt = S_A;
            end
            default: nxt = S_A;
        endcase
    end

    // Operands load on their step; results latch only on the EXEC edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            A      <= '0;
            B      <= '0;
            F      <= '0;
            Y_q    <= '0;
            Cout_q <= 1'b0;
            OV_q   <= 1'b0;
        end else begin
            if (step && state == S_A)
                A <= sw[N-1:0];
            if (step && state == S_B)
                B <= sw[N-1:0];
            if (step && state == S_F)
                F <= sw[FW-1:0];
            if (state == S_EXEC) begin
                Y_q    <= Y_in;
                Cout_q <= Cout_in;
                OV_q   <= OV_in;
            end
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed and randomized checks of the ALU operand sequencer.
module tb_alu_operand_sequencer;

    localparam int N  = 4;
    localparam int FW = 4;
    localparam int DB = 4;
`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int LAT   = 3 + DB;
    localparam int NSTEP = 1;
`else
    localparam int LAT   = 3;
    localparam int NSTEP = 6;
`endif
    localparam logic [3:0] ADD = 4'h1;

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic          btn     = 1'b0;
    logic [3:0]    sw      = '0;
    logic [N-1:0]  Y_in    = '0;
    logic          Cout_in = 1'b0;
    logic          OV_in   = 1'b0;
    logic [N-1:0]  A;
    logic [N-1:0]  B;
    logic [FW-1:0] F;
    logic          alu_go;
    logic [N-1:0]  Y_q;
    logic          Cout_q;
    logic          OV_q;
    logic          valid;
    logic [2:0]    phase;

    alu_operand_sequencer #(
        .N         (N),
        .FW        (FW),
        .DB_CYCLES (DB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sw      (sw),
        .btn     (btn),
        .A       (A),
        .B       (B),
        .F       (F),
        .alu_go  (alu_go),
        .Y_in    (Y_in),
        .Cout_in (Cout_in),
        .OV_in   (OV_in),
        .Y_q     (Y_q),
        .Cout_q  (Cout_q),
        .OV_q    (OV_q),
        .valid   (valid),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model: the entry sequence as a simple step counter.
    int       m_ph;
    logic [3:0] m_a, m_b, m_f, m_y;
    logic       m_c, m_o;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_ph = 0; m_a = 0; m_b = 0; m_f = 0; m_y = 0; m_c = 0; m_o = 0;
    endtask

    task automatic m_step(input logic [3:0] v);
        case (m_ph)
            0: begin m_a = v; m_ph = 1; end
            1: begin m_b = v; m_ph = 2; end
            2: begin m_f = v; m_ph = 3; end
            4: m_ph = 0;
            default: ;
        endcase
    endtask

    task automatic m_exec();
        m_y = Y_in; m_c = Cout_in; m_o = OV_in; m_ph = 4;
    endtask

    task automatic m_apply(input logic [3:0] v);
        m_step(v);
        if (m_ph == 3) m_exec();
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".phase"}, 32'(phase), 32'(m_ph));
        chk({tag, ".A"}, 32'(A), 32'(m_a));
        chk({tag, ".B"}, 32'(B), 32'(m_b));
        chk({tag, ".F"}, 32'(F), 32'(m_f));
        chk({tag, ".Y_q"}, 32'(Y_q), 32'(m_y));
        chk({tag, ".Cout_q"}, 32'(Cout_q), 32'(m_c));
        chk({tag, ".OV_q"}, 32'(OV_q), 32'(m_o));
        chk({tag, ".valid"}, 32'(valid), 32'(m_ph == 4));
        chk({tag, ".alu_go"}, 32'(alu_go), 32'(m_ph == 3));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Press and hold; confirm nothing happens one cycle early, then the load.
    task automatic press(input string tag, input logic [3:0] v);
        sw  = v;
        btn = 1'b1;
        repeat (LAT - 1) tick();
        chk({tag, ".early"}, 32'(phase), 32'(m_ph));
        tick();
        m_step(v);
        check_all(tag);
    endtask

    task automatic release_btn();
        btn = 1'b0;
        repeat (LAT + 3) tick();
    endtask

    task automatic show(input string tag);
        tick();
        m_exec();
        check_all(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ra, rb, rf, ry;
        m_reset();
        #1 reset = 1'b1;
        #1 check_all("reset");
        tick();
        tick();
        reset = 1'b0;
        repeat (4) tick();

        // Full sequence with ADD: 3 + 5 = 8
        Y_in = 4'd8;
        press("seqA", 4'd3);
        release_btn();
        press("seqB", 4'd5);
        release_btn();
        press("seqF", ADD);
        show("seqShow");
        release_btn();

        // Return from SHOW keeps Y_q until the next EXEC
        Y_in = 4'd2;
        press("ret", 4'd0);
        release_btn();
        check_all("retHold");

        // Held button produces a single step
        press("held", 4'h9);
        repeat (50) tick();
        check_all("held50");
        release_btn();

        // Reset in S_F clears everything without a clock edge
        press("toF", 4'd5);
        release_btn();
        tick();
        #1 reset = 1'b1;
        #1;
        m_reset();
        check_all("midrst");

        // Press held through reset release is ignored
        btn = 1'b1;
        tick();
        reset = 1'b0;
        repeat (20) tick();
        check_all("heldrst");
        release_btn();

        // Full-scale switches and flags captured only at EXEC
        Cout_in = 1'b1;
        OV_in   = 1'b1;
        Y_in    = 4'hE;
        press("wideA", 4'hF);
        release_btn();
        press("wideB", 4'h1);
        release_btn();
        press("wideF", ADD);
        show("wideShow");
        release_btn();
        Cout_in = 1'b0;
        OV_in   = 1'b0;
        press("wideRet", 4'h0);
        release_btn();

        // Bouncing button, then a clean held press
        sw = 4'h6;
        for (int i = 0; i < 10; i++) begin
            btn = ~btn;
            repeat (2) tick();
        end
        btn = 1'b1;
        for (int k = 0; k < NSTEP - 1; k++) m_apply(4'h6);
        repeat (LAT - 1) tick();
        check_all("bounceEarly");
        tick();
        m_apply(4'h6);
        check_all("bounce");
        release_btn();

        // Return to S_A for the random sequences
        reset = 1'b1;
        #1;
        m_reset();
        tick();
        reset = 1'b0;
        repeat (4) tick();

        for (int it = 0; it < 12; it++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rf = 4'($urandom_range(0, 15));
            ry = 4'($urandom_range(0, 15));
            Cout_in = 1'($urandom_range(0, 1));
            OV_in   = 1'($urandom_range(0, 1));
            Y_in    = ry;
            press("rndA", ra);
            release_btn();
            press("rndB", rb);
            release_btn();
            press("rndF", rf);
            show("rndShow");
            Y_in    = ~ry;
            Cout_in = ~Cout_in;
            OV_in   = ~OV_in;
            release_btn();
            check_all("rndHold");
            press("rndRet", 4'($urandom_range(0, 15)));
            release_btn();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Upstream input stage for the 4-bit ALU on the FPGA board. It turns one shared set of switches plus a single push button into a stepped entry sequence: load A, then B, then the function code F, then execute. It registers the operands and function that drive the ALU, and captures the ALU's combinational result (Y, Cout, OV) into stable registers for the display stage.

## Interface
Parameters:
- N, 4, operand width for A, B and Y.
- FW, 4, function-code width for F.
- DB_CYCLES, 500000, cycles the synchronised button must stay stable before it is accepted. Used only when debouncing is compiled in.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sw  in  max(N,FW)  raw slide switches; they carry the value to be loaded.
- btn  in  1  raw step push button, active-high, asynchronous to clk.
- A  out  N  registered operand A, fed to the ALU.
- B  out  N  registered operand B, fed to the ALU.
- F  out  FW  registered ALU function code.
- alu_go  out  1  single-cycle pulse, high during the EXEC state.
- Y_in  in  N  combinational ALU result.
- Cout_in  in  1  ALU carry out.
- OV_in  in  1  ALU overflow flag.
- Y_q  out  N  captured ALU result.
- Cout_q  out  1  captured carry.
- OV_q  out  1  captured overflow.
- valid  out  1  high while the captured result is current (SHOW state).
- phase  out  3  encoded current state, for the status LEDs.

## Operation
- btn passes through a 2-flop synchroniser, then an optional debouncer, then a rising-edge detector. The detector output is `step`, a one-cycle pulse.
- States and transitions. Encoding is S_A=0, S_B=1, S_F=2, S_EXEC=3, S_SHOW=4.
  - S_A: on step, A <= sw[N-1:0]; go to S_B.
  - S_B: on step, B <= sw[N-1:0]; go to S_F.
  - S_F: on step, F <= sw[FW-1:0]; go to S_EXEC.
  - S_EXEC: lasts exactly one cycle. alu_go=1. On the closing edge, Y_q/Cout_q/OV_q <= Y_in/Cout_in/OV_in. Go to S_SHOW.
  - S_SHOW: valid=1. A, B, F and the captured results hold. On step, go to S_A and clear valid. A/B/F keep their values until they are reloaded.
- Any step that arrives during S_EXEC is discarded.
- A held button produces exactly one step. A new step needs a release followed by a fresh press.
- Switch bits above N (or above FW) are ignored for that load.
- phase equals the state encoding.

## Timing
- Reset (asynchronous, any state) forces the following, with no clock needed:
  - state = S_A.
  - A, B, F, Y_q = 0.
  - Cout_q, OV_q, alu_go, valid = 0.
  - synchroniser, debounce counter and edge-detector history = 0.
- A press held through reset release is not seen as a step until it is released and pressed again.
- Latency from a btn rising edge to the register load:
  - without debouncing: 3 cycles (2 synchroniser flops, then the edge detector).
  - with debouncing: 3 + DB_CYCLES cycles.
- The ALU sees A/B/F stable for at least one full cycle before EXEC captures the result.
- valid rises on the edge that ends S_EXEC. It falls on the edge on which the S_SHOW step is taken.
- Reset asserted mid-sequence aborts the sequence with no partial capture.

## Configuration
- Macro: ALU_SEQ_DEBOUNCE_EN.
- Defined: a counter runs while the synchronised level differs from the accepted level. It resets whenever the level toggles. The accepted level updates only after DB_CYCLES consecutive stable cycles.
- Undefined: the synchronised level is used directly, and DB_CYCLES is ignored.

## Structure
- Package alu_seq_pkg holds:
  - the state enum (S_A..S_EXEC/S_SHOW, 3-bit);
  - default widths N=4 and FW=4;
  - the phase-encoding constants.
- The natural sub-module is button_conditioner: synchroniser, the debouncer (only when ALU_SEQ_DEBOUNCE_EN is defined) and the edge detector, producing `step`.
- The FSM and data registers live in alu_operand_sequencer.

## Test plan
Bench runs with DB_CYCLES=4.
- Full sequence: sw=3, step; sw=5, step; sw=ADD code, step; Y_in=8 driven by the ALU -> A=3, B=5, alu_go one cycle, Y_q=8, valid=1, phase=4.
- Held button: btn high for 50 cycles in S_A -> exactly one load, state moves to S_B only.
- Bounce (debounce build): btn toggles every 2 cycles for 20 cycles, then stays high -> one step, taken 3+4 cycles after the final rise. Non-debounce build under the same stimulus -> multiple steps.
- Reset mid-sequence: in S_F with A=3 and B=5, pulse reset -> A=B=F=Y_q=0, valid=0, phase=0, immediately and without a clock edge.
- Return from SHOW: step in S_SHOW -> valid=0, phase=0, Y_q holds 8 until the next EXEC.
- Wide switches: N=4, sw=4'hF loaded into A, then a sequence with Cout_in=1 and OV_in=1 -> Cout_q=1 and OV_q=1 captured only at EXEC.
